multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- FSM that sequences the RV32I datapath over multiple cycles: fetch, decode, execute, memory, writeback.
- Drives the PC/IR/regfile enables, ALU control and operand muxes, immediate select and the shared instruction/data memory port.
- Sits between the instruction register and the datapath. It is the multi-cycle successor to the combinational controller.
- ALU encoding is fixed: 0000 add, 0001 sub, 0010 sll, 0011 slt, 0100 sltu, 0101 xor, 0110 srl, 0111 sra, 1000 or, 1001 and.

Parameters:
- MEM_WAIT_MAX, 15: cycles mem_req may stay unanswered before fault; 0 disables the watchdog.
- WDOG_W, 4: watchdog counter width; must hold MEM_WAIT_MAX.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- instr  in  32  current IR contents.
- mem_ready  in  1  memory completes the access this cycle.
- branch_taken  in  1  comparator result for the current branch, valid in BRANCH.
- pc_we  out  1  PC update enable.
- pc_src  out  2  PC source: 00 pc+4, 01 pc+imm, 10 ALU result with bit0 cleared.
- ir_we  out  1  IR load enable.
- reg_we  out  1  regfile write enable.
- alu_ctrl  out  4  ALU operation.
- alu_src_a  out  1  A operand: 0 rs1, 1 pc.
- alu_src_b  out  1  B operand: 0 rs2, 1 imm.
- imm_type  out  3  immediate format: 000 I, 001 S, 010 B, 011 U, 100 J.
- mem_req  out  1  memory request.
- mem_we  out  1  store.
- mem_addr_sel  out  1  memory address: 0 pc, 1 ALU result.
- wb_sel  out  2  writeback source: 00 alu, 01 mem, 10 pc+4, 11 imm.
- instr_retired  out  1  one-cycle pulse on the final cycle of each instruction.
- mem_fault  out  1  sticky watchdog fault.
- illegal_instr  out  1  sticky illegal-opcode flag; only with ILLEGAL_TRAP_EN.
- state_o  out  4  current state, for debug.

Behaviour:
- States: FETCH, DECODE, EXECUTE, MEM_ADDR, MEM_ACCESS, WRITEBACK, BRANCH, JUMP, HALT.
- Reset: state = FETCH, watchdog = 0, mem_fault = 0, illegal_instr = 0.
- Default outputs, when no state below asserts them: all enables 0, alu_ctrl add, all selects 0.

State actions and transitions:
- FETCH: mem_req=1, mem_we=0, mem_addr_sel=0. On mem_ready, ir_we=1 in the same cycle, then DECODE. Otherwise stay.
- DECODE (1 cycle), dispatch on instr[6:0]:
  - 0110011, 0010011, 0110111 (LUI), 0010111 (AUIPC) -> EXECUTE.
  - 0000011 (load), 0100011 (store) -> MEM_ADDR.
  - 1100011 -> BRANCH.
  - 1101111 (JAL), 1100111 (JALR) -> JUMP.
  - Any other opcode -> WRITEBACK with reg_we suppressed, i.e. treated as a NOP.
- EXECUTE, R-type: alu_ctrl from funct3 / instr[30] per the fixed encoding.
- EXECUTE, I-type: same decode, but instr[30] is ignored except for funct3=101, where 0 selects srli and 1 selects srai. alu_src_b=1, imm_type=I.
- EXECUTE, AUIPC: alu_src_a=1, alu_src_b=1, imm_type=U, add.
- EXECUTE, LUI: no ALU requirement; writeback uses wb_sel=11. Then WRITEBACK.
- MEM_ADDR: add, alu_src_b=1; imm_type=I for loads, S for stores. Then MEM_ACCESS.
- MEM_ACCESS: mem_req=1, mem_addr_sel=1, mem_we = store. Holds until mem_ready.
  - Load -> WRITEBACK with wb_sel=01.
  - Store -> pc_we=1, pc_src=00, instr_retired=1, then FETCH.
- WRITEBACK: reg_we=1 unless rd==0 or NOP; pc_we=1, pc_src=00, instr_retired=1. Then FETCH.
- BRANCH: imm_type=B; alu_ctrl = sub for beq/bne, slt for blt/bge, sltu for bltu/bgeu. pc_we=1; pc_src=01 if branch_taken, else 00; instr_retired=1. Then FETCH.
- JUMP: reg_we=1 (unless rd==0), wb_sel=10, pc_we=1, instr_retired=1. JAL: pc_src=01, imm_type=J. JALR: pc_src=10, add, alu_src_b=1, imm_type=I. Then FETCH.
- HALT: all enables 0; left only by reset.

Latency (zero-wait memory):
- R/I/LUI/AUIPC 4 cycles, load 5, store 4, branch 3, jump 3.
- mem_ready in the same cycle as mem_req counts as zero wait.

Watchdog:
- Counts cycles with mem_req=1 and mem_ready=0; clears on mem_ready or on any state change.
- Reaching MEM_WAIT_MAX sets mem_fault and goes to HALT.
- mem_ready arriving in the same cycle as expiry wins: no fault.

Reset mid-operation: returns to FETCH immediately; no partial write completes after rst_n falls.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Defined: an unknown opcode in DECODE sets illegal_instr and goes to HALT. R-type with funct7 other than 0000000/0100000, or 0100000 with funct3 not 000/101, is also illegal.
- Undefined: illegal_instr is tied to 0 and unknown opcodes retire as a NOP (PC+4, no writes).

Decomposition:
- Shared package holds: opcode constants, ALU_CTRL codes, IMM_TYPE codes, WB_SEL and PC_SRC codes, and the state enum.
- One sub-module: alu_ctrl_decoder, a combinational map from funct3/instr[30]/instruction class to alu_ctrl.

Test Plan:
- add x3,x1,x2 (0x002081B3), mem_ready always 1 -> states FETCH, DECODE, EXECUTE, WRITEBACK; alu_ctrl=0000; reg_we=1 only in cycle 4; one instr_retired pulse.
- srai x5,x5,3 (0x4032D293) -> alu_ctrl=0111, alu_src_b=1. Then srli (0x0032D293) -> alu_ctrl=0110.
- lw x4,8(x1) with mem_ready delayed 3 cycles in MEM_ACCESS -> MEM_ACCESS held 4 cycles, mem_addr_sel=1, then WRITEBACK with wb_sel=01; total 8 cycles.
- beq taken / not taken (0x00208463), branch_taken=1 then 0 -> pc_src=01 then 00; reg_we never asserted.
- mem_ready held 0 in FETCH with MEM_WAIT_MAX=15 -> mem_fault=1 after 15 cycles, state HALT, outputs idle. Pulsing rst_n low mid-HALT -> FETCH next cycle, mem_fault=0.
- Opcode 0x0000007F -> NOP retire (pc_we=1, reg_we=0) without ILLEGAL_TRAP_EN; illegal_instr=1 and HALT with it.

Source files
------------

// File: rtl/multicycle_controller_pkg.sv
// rtl/multicycle_controller_pkg.sv - shared encodings for the RV32I multi-cycle controller
// Purpose: opcode constants, ALU/immediate/writeback/PC-source codes, FSM state codes
//          and the instruction class fed to the ALU control decoder.
// Ports:   none (package).
package multicycle_controller_pkg;

  // Major opcodes (instr[6:0])
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // ALU operation codes
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLL  = 4'b0010;
  localparam logic [3:0] ALU_SLT  = 4'b0011;
  localparam logic [3:0] ALU_SLTU = 4'b0100;
  localparam logic [3:0] ALU_XOR  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_OR   = 4'b1000;
  localparam logic [3:0] ALU_AND  = 4'b1001;

  // Immediate formats
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  // Writeback sources
  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;
  localparam logic [1:0] WB_IMM = 2'b11;

  // PC sources
  localparam logic [1:0] PC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_IMM   = 2'b01;
  localparam logic [1:0] PC_ALU   = 2'b10;

  // FSM states
  localparam logic [3:0] ST_FETCH      = 4'd0;
  localparam logic [3:0] ST_DECODE     = 4'd1;
  localparam logic [3:0] ST_EXECUTE    = 4'd2;
  localparam logic [3:0] ST_MEM_ADDR   = 4'd3;
  localparam logic [3:0] ST_MEM_ACCESS = 4'd4;
  localparam logic [3:0] ST_WRITEBACK  = 4'd5;
  localparam logic [3:0] ST_BRANCH     = 4'd6;
  localparam logic [3:0] ST_JUMP       = 4'd7;
  localparam logic [3:0] ST_HALT       = 4'd8;

  // Instruction class as seen by the ALU control decoder
  typedef enum logic [1:0] {
    ACLS_ADD = 2'b00,
    ACLS_R   = 2'b01,
    ACLS_I   = 2'b10,
    ACLS_BR  = 2'b11
  } alu_class_e;

endpackage

// File: rtl/alu_ctrl_decoder.sv
// rtl/alu_ctrl_decoder.sv - combinational funct3/instr[30]/class to alu_ctrl map
// Purpose: selects the ALU operation for register, immediate and branch instructions.
// Ports:   class_i   instruction class (add-only, R, I, branch)
//          funct3_i  instr[14:12]
//          bit30_i   instr[30] (sub/sra select)
//          alu_ctrl_o ALU operation code
module alu_ctrl_decoder
  import multicycle_controller_pkg::*;
(
  input  alu_class_e class_i,
  input  logic [2:0] funct3_i,
  input  logic       bit30_i,
  output logic [3:0] alu_ctrl_o
);

  always_comb begin
    alu_ctrl_o = ALU_ADD;
    case (class_i)
      ACLS_R, ACLS_I: begin
        case (funct3_i)
          // Immediate add has no subtract form; instr[30] is part of the immediate.
          3'b000:  alu_ctrl_o = (class_i == ACLS_R && bit30_i) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_ctrl_o = ALU_SLL;
          3'b010:  alu_ctrl_o = ALU_SLT;
          3'b011:  alu_ctrl_o = ALU_SLTU;
          3'b100:  alu_ctrl_o = ALU_XOR;
          3'b101:  alu_ctrl_o = bit30_i ? ALU_SRA : ALU_SRL;
          3'b110:  alu_ctrl_o = ALU_OR;
          default: alu_ctrl_o = ALU_AND;
        endcase
      end
      ACLS_BR: begin
        // funct3[0] only inverts the sense, so the pair shares one compare.
        case (funct3_i[2:1])
          2'b10:   alu_ctrl_o = ALU_SLT;
          2'b11:   alu_ctrl_o = ALU_SLTU;
          default: alu_ctrl_o = ALU_SUB;
        endcase
      end
      default: alu_ctrl_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multi-cycle RV32I control FSM
// Purpose: sequences fetch/decode/execute/memory/writeback and drives datapath enables,
//          ALU control, operand muxes, immediate select and the shared memory port.
//          Optional ILLEGAL_TRAP_EN: unknown opcodes / bad R-type funct7 set
//          illegal_instr and halt; otherwise they retire as a NOP.
// Ports:   clk, rst_n (async, active-low); instr, mem_ready, branch_taken inputs;
//          pc_we/pc_src, ir_we, reg_we, alu_ctrl, alu_src_a/b, imm_type, mem_req,
//          mem_we, mem_addr_sel, wb_sel, instr_retired, mem_fault, illegal_instr, state_o.
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15,
  parameter int WDOG_W       = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  input  logic        branch_taken,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic        ir_we,
  output logic        reg_we,
  output logic [3:0]  alu_ctrl,
  output logic        alu_src_a,
  output logic        alu_src_b,
  output logic [2:0]  imm_type,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic [1:0]  wb_sel,
  output logic        instr_retired,
  output logic        mem_fault,
  output logic        illegal_instr,
  output logic [3:0]  state_o
);

  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'((MEM_WAIT_MAX > 0) ? MEM_WAIT_MAX - 1 : 0);

  logic [3:0]        state_q, state_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              mem_fault_q, mem_fault_d;
  logic              illegal_d;
  logic              wait_cyc;
  alu_class_e        alu_class;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       rd_nz;
  logic       is_store;
  logic       writes_rd;

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign rd_nz    = |instr[11:7];
  assign is_store = (opcode == OP_STORE);
  // Unknown opcodes reach WRITEBACK too, so the write is gated by opcode.
  assign writes_rd = (opcode == OP_R) || (opcode == OP_I) || (opcode == OP_LUI) ||
                     (opcode == OP_AUIPC) || (opcode == OP_LOAD);

  logic unused_instr_bits;
  assign unused_instr_bits = ^instr[31:15];

  // Kept separate from the main FSM block so the decoder output does not loop back into it.
  always_comb begin
    alu_class = ACLS_ADD;
    if (state_q == ST_EXECUTE && opcode == OP_R) alu_class = ACLS_R;
    if (state_q == ST_EXECUTE && opcode == OP_I) alu_class = ACLS_I;
    if (state_q == ST_BRANCH)                    alu_class = ACLS_BR;
  end

  alu_ctrl_decoder u_alu_ctrl_decoder (
    .class_i   (alu_class),
    .funct3_i  (funct3),
    .bit30_i   (instr[30]),
    .alu_ctrl_o(alu_ctrl)
  );

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q;
  logic r_legal;
  assign r_legal = (instr[31:25] == 7'b0000000) ||
                   (instr[31:25] == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101));
`endif

  always_comb begin
    pc_we         = 1'b0;
    pc_src        = PC_PLUS4;
    ir_we         = 1'b0;
    reg_we        = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 1'b0;
    imm_type      = IMM_I;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr_sel  = 1'b0;
    wb_sel        = WB_ALU;
    instr_retired = 1'b0;
    state_d       = state_q;
    wdog_d        = '0;
    mem_fault_d   = mem_fault_q;
    illegal_d     = 1'b0;
    wait_cyc      = 1'b0;

    case (state_q)
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          state_d = ST_DECODE;
        end else begin
          wait_cyc = 1'b1;
        end
      end
      ST_DECODE: begin
        case (opcode)
          OP_R: begin
`ifdef ILLEGAL_TRAP_EN
            if (!r_legal) begin
              illegal_d = 1'b1;
              state_d   = ST_HALT;
            end else begin
              state_d = ST_EXECUTE;
            end
`else
            state_d = ST_EXECUTE;
`endif
          end
          OP_I, OP_LUI, OP_AUIPC: state_d = ST_EXECUTE;
          OP_LOAD, OP_STORE:      state_d = ST_MEM_ADDR;
          OP_BRANCH:              state_d = ST_BRANCH;
          OP_JAL, OP_JALR:        state_d = ST_JUMP;
          default: begin
`ifdef ILLEGAL_TRAP_EN
            illegal_d = 1'b1;
            state_d   = ST_HALT;
`else
            state_d = ST_WRITEBACK;
`endif
          end
        endcase
      end
      ST_EXECUTE: begin
        if (opcode == OP_I) begin
          alu_src_b = 1'b1;
          imm_type  = IMM_I;
        end else if (opcode == OP_AUIPC) begin
          alu_src_a = 1'b1;
          alu_src_b = 1'b1;
          imm_type  = IMM_U;
        end else if (opcode == OP_LUI) begin
          imm_type = IMM_U;
        end
        state_d = ST_WRITEBACK;
      end
      ST_MEM_ADDR: begin
        alu_src_b = 1'b1;
        imm_type  = is_store ? IMM_S : IMM_I;
        state_d   = ST_MEM_ACCESS;
      end
      ST_MEM_ACCESS: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = is_store;
        if (mem_ready) begin
          if (is_store) begin
            pc_we         = 1'b1;
            instr_retired = 1'b1;
            state_d       = ST_FETCH;
          end else begin
            state_d = ST_WRITEBACK;
          end
        end else begin
          wait_cyc = 1'b1;
        end
      end
      ST_WRITEBACK: begin
        reg_we        = writes_rd && rd_nz;
        wb_sel        = (opcode == OP_LOAD) ? WB_MEM : (opcode == OP_LUI) ? WB_IMM : WB_ALU;
        pc_we         = 1'b1;
        instr_retired = 1'b1;
        state_d       = ST_FETCH;
      end
      ST_BRANCH: begin
        imm_type      = IMM_B;
        pc_we         = 1'b1;
        pc_src        = branch_taken ? PC_IMM : PC_PLUS4;
        instr_retired = 1'b1;
        state_d       = ST_FETCH;
      end
      ST_JUMP: begin
        reg_we        = rd_nz;
        wb_sel        = WB_PC4;
        pc_we         = 1'b1;
        instr_retired = 1'b1;
        if (opcode == OP_JAL) begin
          pc_src   = PC_IMM;
          imm_type = IMM_J;
        end else begin
          pc_src    = PC_ALU;
          alu_src_b = 1'b1;
          imm_type  = IMM_I;
        end
        state_d = ST_FETCH;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase

    // Expiry only fires on a cycle without mem_ready, so a late answer still wins.
    if (wait_cyc && MEM_WAIT_MAX != 0) begin
      if (wdog_q == WDOG_LAST) begin
        mem_fault_d = 1'b1;
        state_d     = ST_HALT;
      end else begin
        wdog_d = wdog_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_FETCH;
      wdog_q      <= '0;
      mem_fault_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wdog_q      <= wdog_d;
      mem_fault_q <= mem_fault_d;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) illegal_q <= 1'b0;
    else if (illegal_d) illegal_q <= 1'b1;
  end
  assign illegal_instr = illegal_q;
`else
  logic unused_illegal;
  assign unused_illegal = illegal_d;
  assign illegal_instr  = 1'b0;
`endif

  assign mem_fault = mem_fault_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - directed self-checking bench for multicycle_controller
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        mem_ready;
  logic        branch_taken;
  logic        pc_we;
  logic [1:0]  pc_src;
  logic        ir_we;
  logic        reg_we;
  logic [3:0]  alu_ctrl;
  logic        alu_src_a;
  logic        alu_src_b;
  logic [2:0]  imm_type;
  logic        mem_req;
  logic        mem_we;
  logic        mem_addr_sel;
  logic [1:0]  wb_sel;
  logic        instr_retired;
  logic        mem_fault;
  logic        illegal_instr;
  logic [3:0]  state_o;

  multicycle_controller #(.MEM_WAIT_MAX(15), .WDOG_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .mem_ready(mem_ready),
    .branch_taken(branch_taken), .pc_we(pc_we), .pc_src(pc_src), .ir_we(ir_we),
    .reg_we(reg_we), .alu_ctrl(alu_ctrl), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .imm_type(imm_type), .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
    .wb_sel(wb_sel), .instr_retired(instr_retired), .mem_fault(mem_fault),
    .illegal_instr(illegal_instr), .state_o(state_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pc_we;
    logic [1:0] pc_src;
    logic       ir_we;
    logic       reg_we;
    logic [3:0] alu;
    logic       src_a;
    logic       src_b;
    logic [2:0] imm;
    logic       mem_req;
    logic       mem_we;
    logic       addr_sel;
    logic [1:0] wb;
    logic       ret;
  } snap_t;

  snap_t       snap [16];
  logic [31:0] trace;
  int          ncyc, n_ma, n_rwe, n_ret;
  int          nerr = 0;
  int          nchk = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic snap_t sample();
    snap_t s;
    s = '{pc_we, pc_src, ir_we, reg_we, alu_ctrl, alu_src_a, alu_src_b, imm_type,
          mem_req, mem_we, mem_addr_sel, wb_sel, instr_retired};
    return s;
  endfunction

  // Runs one instruction from FETCH until it retires (or halts); called at a negedge.
  task automatic run(input logic [31:0] ins, input int ma_wait, input logic bt);
    logic done;
    done  = 1'b0;
    instr = ins;
    trace = '0;
    ncyc  = 0;
    n_ma  = 0;
    n_rwe = 0;
    n_ret = 0;
    while (!done && ncyc < 40) begin
      mem_ready    = !(state_o == 4'd4 && n_ma < ma_wait);
      branch_taken = bt;
      #1;
      snap[state_o] = sample();
      trace = {trace[27:0], state_o};
      ncyc++;
      if (state_o == 4'd4) n_ma++;
      n_rwe += int'(reg_we);
      n_ret += int'(instr_retired);
      if (instr_retired || state_o == 4'd8) done = 1'b1;
      @(negedge clk);
    end
    chk("run_done", {31'd0, done}, 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Holds mem_ready low in FETCH; with tie set, mem_ready rises on the expiry cycle.
  task automatic wdog_test(input logic tie);
    for (int i = 0; i < 15; i++) begin
      mem_ready = tie && (i == 14);
      #1;
      if (i == 14) begin
        chk("wd_pre_state", {28'd0, state_o}, 32'd0);
        chk("wd_pre_fault", {31'd0, mem_fault}, 32'd0);
      end
      @(negedge clk);
    end
    mem_ready = 1'b0;
    #1;
    if (tie) begin
      chk("wd_tie_state", {28'd0, state_o}, 32'd1);
      chk("wd_tie_fault", {31'd0, mem_fault}, 32'd0);
    end else begin
      chk("wd_halt_state", {28'd0, state_o}, 32'd8);
      chk("wd_fault", {31'd0, mem_fault}, 32'd1);
      chk("wd_halt_req", {31'd0, mem_req}, 32'd0);
      chk("wd_halt_pcwe", {31'd0, pc_we}, 32'd0);
    end
  endtask

  initial begin
    rst_n        = 1'b1;
    instr        = 32'h0;
    mem_ready    = 1'b0;
    branch_taken = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_state", {28'd0, state_o}, 32'd0);
    chk("rst_fault", {31'd0, mem_fault}, 32'd0);
    chk("rst_illegal", {31'd0, illegal_instr}, 32'd0);
    chk("rst_pcwe", {31'd0, pc_we}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // add x3,x1,x2
    run(32'h002081B3, 0, 1'b0);
    chk("add_trace", trace, 32'h0125);
    chk("add_cycles", ncyc, 4);
    chk("add_irwe", {31'd0, snap[0].ir_we}, 32'd1);
    chk("add_alu", {28'd0, snap[2].alu}, 32'h0);
    chk("add_regwe_cnt", n_rwe, 1);
    chk("add_regwe_wb", {31'd0, snap[5].reg_we}, 32'd1);
    chk("add_retired", n_ret, 1);

    // srai x5,x5,3 then srli
    run(32'h4032D293, 0, 1'b0);
    chk("srai_alu", {28'd0, snap[2].alu}, 32'h7);
    chk("srai_srcb", {31'd0, snap[2].src_b}, 32'd1);
    chk("srai_imm", {29'd0, snap[2].imm}, 32'd0);
    run(32'h0032D293, 0, 1'b0);
    chk("srli_alu", {28'd0, snap[2].alu}, 32'h6);

    // auipc x2,0
    run(32'h00000117, 0, 1'b0);
    chk("auipc_srca", {31'd0, snap[2].src_a}, 32'd1);
    chk("auipc_imm", {29'd0, snap[2].imm}, 32'd3);

    // lui x1,1
    run(32'h000010B7, 0, 1'b0);
    chk("lui_trace", trace, 32'h0125);
    chk("lui_wb", {30'd0, snap[5].wb}, 32'd3);

    // lw x4,8(x1) with three wait cycles in MEM_ACCESS
    run(32'h0080A203, 3, 1'b0);
    chk("lw_trace", trace, 32'h01344445);
    chk("lw_cycles", ncyc, 8);
    chk("lw_ma_cycles", n_ma, 4);
    chk("lw_addr_sel", {31'd0, snap[4].addr_sel}, 32'd1);
    chk("lw_mem_we", {31'd0, snap[4].mem_we}, 32'd0);
    chk("lw_addr_imm", {29'd0, snap[3].imm}, 32'd0);
    chk("lw_wb", {30'd0, snap[5].wb}, 32'd1);
    chk("lw_regwe", {31'd0, snap[5].reg_we}, 32'd1);

    // sw x2,4(x1)
    run(32'h0020A223, 0, 1'b0);
    chk("sw_trace", trace, 32'h0134);
    chk("sw_imm", {29'd0, snap[3].imm}, 32'd1);
    chk("sw_mem_we", {31'd0, snap[4].mem_we}, 32'd1);
    chk("sw_pcwe", {31'd0, snap[4].pc_we}, 32'd1);
    chk("sw_regwe_cnt", n_rwe, 0);

    // beq taken / not taken, blt
    run(32'h00208463, 0, 1'b1);
    chk("beq_t_trace", trace, 32'h016);
    chk("beq_t_pcsrc", {30'd0, snap[6].pc_src}, 32'd1);
    chk("beq_alu", {28'd0, snap[6].alu}, 32'h1);
    chk("beq_imm", {29'd0, snap[6].imm}, 32'd2);
    chk("beq_regwe_cnt", n_rwe, 0);
    run(32'h00208463, 0, 1'b0);
    chk("beq_nt_pcsrc", {30'd0, snap[6].pc_src}, 32'd0);
    chk("beq_nt_pcwe", {31'd0, snap[6].pc_we}, 32'd1);
    run(32'h0020C463, 0, 1'b0);
    chk("blt_alu", {28'd0, snap[6].alu}, 32'h3);

    // jal x1 / jalr x0,0(x1)
    run(32'h000000EF, 0, 1'b0);
    chk("jal_trace", trace, 32'h017);
    chk("jal_regwe", {31'd0, snap[7].reg_we}, 32'd1);
    chk("jal_wb", {30'd0, snap[7].wb}, 32'd2);
    chk("jal_pcsrc", {30'd0, snap[7].pc_src}, 32'd1);
    chk("jal_imm", {29'd0, snap[7].imm}, 32'd4);
    run(32'h00008067, 0, 1'b0);
    chk("jalr_regwe", {31'd0, snap[7].reg_we}, 32'd0);
    chk("jalr_pcsrc", {30'd0, snap[7].pc_src}, 32'd2);
    chk("jalr_srcb", {31'd0, snap[7].src_b}, 32'd1);

    // unknown opcodes
`ifdef ILLEGAL_TRAP_EN
    run(32'h0000007F, 0, 1'b0);
    chk("ill_trace", trace, 32'h018);
    chk("ill_flag", {31'd0, illegal_instr}, 32'd1);
    do_reset();
    #1;
    chk("ill_rst_flag", {31'd0, illegal_instr}, 32'd0);
    @(negedge clk);
    run(32'h40001033, 0, 1'b0);
    chk("ill_r_trace", trace, 32'h018);
    do_reset();
`else
    run(32'h0000007F, 0, 1'b0);
    chk("nop_trace", trace, 32'h015);
    chk("nop_pcwe", {31'd0, snap[5].pc_we}, 32'd1);
    chk("nop_regwe", {31'd0, snap[5].reg_we}, 32'd0);
    chk("nop_illegal", {31'd0, illegal_instr}, 32'd0);
    run(32'h00000F8B, 0, 1'b0);
    chk("nop_rd31_regwe", n_rwe, 0);
    chk("nop_rd31_ret", n_ret, 1);
    do_reset();
`endif

    // watchdog: answer on the expiry cycle wins, then a real timeout
    wdog_test(1'b1);
    do_reset();
    wdog_test(1'b0);
    mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("halt_hold", {28'd0, state_o}, 32'd8);
    #1 rst_n = 1'b0;
    #1;
    chk("halt_rst_state", {28'd0, state_o}, 32'd0);
    chk("halt_rst_fault", {31'd0, mem_fault}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_req", {31'd0, mem_req}, 32'd1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
